// File: rtl/sdram_param.sv
// Shared definitions for the SDRAM work FSM: state codes, SDRAM command
// encodings and the system address field layout.
package sdram_param;

    // Work FSM state codes; the 5-bit width is what work_state exports.
    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_ACTIVE  = 5'd1,
        S_TRCD    = 5'd2,
        S_READ    = 5'd3,
        S_CL      = 5'd4,
        S_RD_DATA = 5'd5,
        S_WR_DATA = 5'd6,
        S_TWR     = 5'd7,
        S_PRECH   = 5'd8,
        S_TRP     = 5'd9,
        S_AR      = 5'd10,
        S_TRFC    = 5'd11
    } work_state_e;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;

    // System address map: {ba[23:22], row[21:9], col[8:0]}.
    localparam int SYS_ADDR_W = 24;
    localparam int BA_HI      = 23;
    localparam int BA_LO      = 22;
    localparam int ROW_HI     = 21;
    localparam int ROW_LO     = 9;
    localparam int COL_HI     = 8;
    localparam int COL_LO     = 0;
    localparam int BA_W       = BA_HI - BA_LO + 1;
    localparam int ROW_W      = ROW_HI - ROW_LO + 1;
    localparam int COL_W      = COL_HI - COL_LO + 1;

    // Precharge with A10 high closes every bank.
    localparam logic [ROW_W-1:0] ADDR_ALL_BANKS = 13'h0400;

    typedef struct packed {
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } sdram_loc_t;

    function automatic sdram_loc_t split_addr(input logic [SYS_ADDR_W-1:0] a);
        sdram_loc_t loc;
        loc.ba  = a[BA_HI:BA_LO];
        loc.row = a[ROW_HI:ROW_LO];
        loc.col = a[COL_HI:COL_LO];
        return loc;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer; raises ref_pending once per
// REF_INTERVAL cycles and keeps it until the FSM starts the refresh.
module sdram_ref_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic ref_pending
);

    localparam int CNT_W = $clog2(REF_INTERVAL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] ref_cnt;
    logic             wrap;

    assign wrap = enable && (ref_cnt == CNT_LAST);

    // Interval counter and pending flag; a fresh interval wins over a clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (!enable || wrap) ref_cnt <= '0;
            else                 ref_cnt <= ref_cnt + 1'b1;

            if (wrap)       ref_pending <= 1'b1;
            else if (clear) ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_work_fsm.sv
// SDRAM work-phase controller: arbitrates refresh/write/read in idle and
// sequences ACTIVE, READ/WRITE bursts, PRECHARGE and AUTO REFRESH.
module sdram_work_fsm
    import sdram_param::*;
#(
    parameter int BL           = 4,
    parameter int CL           = 3,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_WR         = 2,
    parameter int T_RFC        = 7,
    parameter int REF_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        sdram_rd_req,
    input  logic        sdram_wr_req,
    input  logic [23:0] sys_rdaddr,
    input  logic [23:0] sys_wraddr,
    output logic        sdram_rd_ack,
    output logic        sdram_wr_ack,
    output logic        sdram_wr_data_valid,
    output logic        sdram_data_i_valid,
    output logic        end_tread,
    output logic        end_twrite,
    output logic        sdram_r_wn,
    output logic [4:0]  work_state,
    output logic [4:0]  cur_work_state,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr
);

    // Cycle counts of each timed state.
    localparam int LEN_TRCD = T_RCD - 1;
    localparam int LEN_CL   = CL - 1;
    localparam int LEN_TRP  = T_RP - 1;
    localparam int LEN_TRFC = T_RFC - 1;

    work_state_e state, state_next;
    logic [3:0]  wait_cnt;
    logic        init_ok;
    logic        ref_pending;
    logic        ref_clear;
    logic        op_write;
    sdram_loc_t  loc;

    // True on the final cycle of a state lasting len cycles (minimum one).
    function automatic logic last_cycle(input logic [3:0] cnt, input int len);
        return (int'(cnt) + 1) >= len;
    endfunction

    assign ref_clear  = (state == S_IDLE) && (state_next == S_AR);
    assign work_state = state;

    sdram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (init_ok),
        .clear       (ref_clear),
        .ref_pending (ref_pending)
    );

    // State register, wait counter, init qualifier and latched burst address.
    // Every output is decoded from these, so resetting them resets the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cur_work_state <= S_IDLE;
            wait_cnt       <= 4'd0;
            init_ok        <= 1'b0;
            op_write       <= 1'b0;
            loc            <= '0;
        end else begin
            state          <= state_next;
            cur_work_state <= state;
            wait_cnt       <= (state_next != state) ? 4'd0 : wait_cnt + 4'd1;
            init_ok        <= init_done;
            if (sdram_wr_ack) begin
                op_write <= 1'b1;
                loc      <= split_addr(sys_wraddr);
            end else if (sdram_rd_ack) begin
                op_write <= 1'b0;
                loc      <= split_addr(sys_rdaddr);
            end
        end
    end

    // Next-state, arbitration and command/strobe decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next          = state;
        sdram_cmd           = CMD_NOP;
        sdram_ba            = '0;
        sdram_addr          = '0;
        sdram_rd_ack        = 1'b0;
        sdram_wr_ack        = 1'b0;
        sdram_wr_data_valid = 1'b0;
        sdram_data_i_valid  = 1'b0;
        end_tread           = 1'b0;
        end_twrite          = 1'b0;
        sdram_r_wn          = 1'b1;

        case (state)
            S_IDLE: begin
                if (init_ok && init_done) begin
                    if (ref_pending) begin
                        state_next = S_AR;
                    end else if (sdram_wr_req) begin
                        sdram_wr_ack = 1'b1;
                        state_next   = S_ACTIVE;
                    end else if (sdram_rd_req) begin
                        sdram_rd_ack = 1'b1;
                        state_next   = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                sdram_cmd  = CMD_ACTIVE;
                sdram_ba   = loc.ba;
                sdram_addr = loc.row;
                state_next = S_TRCD;
            end
            S_TRCD: begin
                if (last_cycle(wait_cnt, LEN_TRCD))
                    state_next = op_write ? S_WR_DATA : S_READ;
            end
            S_READ: begin
                sdram_cmd  = CMD_READ;
                sdram_ba   = loc.ba;
                sdram_addr = {4'b0, loc.col};
                state_next = S_CL;
            end
            S_CL: begin
                if (last_cycle(wait_cnt, LEN_CL)) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                sdram_data_i_valid = 1'b1;
                if (last_cycle(wait_cnt, BL)) begin
                    end_tread  = 1'b1;
                    state_next = S_PRECH;
                end
            end
            S_WR_DATA: begin
                sdram_wr_data_valid = 1'b1;
                sdram_r_wn          = 1'b0;
                sdram_ba            = loc.ba;
                sdram_addr          = {4'b0, loc.col};
                if (wait_cnt == 4'd0) sdram_cmd = CMD_WRITE;
                if (last_cycle(wait_cnt, BL)) begin
                    end_twrite = 1'b1;
                    state_next = S_TWR;
                end
            end
            S_TWR: begin
                if (last_cycle(wait_cnt, T_WR)) state_next = S_PRECH;
            end
            S_PRECH: begin
                sdram_cmd  = CMD_PRECHARGE;
                sdram_ba   = loc.ba;
                sdram_addr = ADDR_ALL_BANKS;
                state_next = S_TRP;
            end
            S_TRP: begin
                if (last_cycle(wait_cnt, LEN_TRP)) state_next = S_IDLE;
            end
            S_AR: begin
                sdram_cmd  = CMD_AREF;
                state_next = S_TRFC;
            end
            S_TRFC: begin
                if (last_cycle(wait_cnt, LEN_TRFC)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_work_fsm.sv
// Directed bench for sdram_work_fsm: per-cycle expectations are queued as
// each transaction is started and compared cycle by cycle at the falling edge.
module tb_sdram_work_fsm;
    import sdram_param::*;

    logic        clk = 1'b0;
    logic        rst, init_done, sdram_rd_req, sdram_wr_req;
    logic [23:0] sys_rdaddr, sys_wraddr;
    logic        sdram_rd_ack, sdram_wr_ack, sdram_wr_data_valid, sdram_data_i_valid;
    logic        end_tread, end_twrite, sdram_r_wn;
    logic [4:0]  work_state, cur_work_state;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    always #5 clk = ~clk;

    sdram_work_fsm #(
        .BL(4), .CL(3), .T_RCD(2), .T_RP(2), .T_WR(2), .T_RFC(7), .REF_INTERVAL(780)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_done           (init_done),
        .sdram_rd_req        (sdram_rd_req),
        .sdram_wr_req        (sdram_wr_req),
        .sys_rdaddr          (sys_rdaddr),
        .sys_wraddr          (sys_wraddr),
        .sdram_rd_ack        (sdram_rd_ack),
        .sdram_wr_ack        (sdram_wr_ack),
        .sdram_wr_data_valid (sdram_wr_data_valid),
        .sdram_data_i_valid  (sdram_data_i_valid),
        .end_tread           (end_tread),
        .end_twrite          (end_twrite),
        .sdram_r_wn          (sdram_r_wn),
        .work_state          (work_state),
        .cur_work_state      (cur_work_state),
        .sdram_cmd           (sdram_cmd),
        .sdram_ba            (sdram_ba),
        .sdram_addr          (sdram_addr)
    );

    // Flag vector {rd_ack, wr_ack, wr_data_valid, data_i_valid, end_tread, end_twrite, r_wn}.
    localparam logic [6:0] F_RACK = 7'b1000000;
    localparam logic [6:0] F_WACK = 7'b0100000;
    localparam logic [6:0] F_WDV  = 7'b0010000;
    localparam logic [6:0] F_DIV  = 7'b0001000;
    localparam logic [6:0] F_ENDR = 7'b0000100;
    localparam logic [6:0] F_ENDW = 7'b0000010;
    localparam logic [6:0] F_RWN  = 7'b0000001;

    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100, C_PRE = 4'b0010, C_AR = 4'b0001;

    typedef struct {
        int          t;
        work_state_e st;
        logic [3:0]  cmd;
        logic        ba_care;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [12:0] amask;
        logic [6:0]  fl;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_valid = 1'b0;
    int          prev_t = 0;
    work_state_e prev_st = S_IDLE;
    logic [6:0]  obs_fl;

    assign obs_fl = {sdram_rd_ack, sdram_wr_ack, sdram_wr_data_valid, sdram_data_i_valid,
                     end_tread, end_twrite, sdram_r_wn};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic exp_t mk(input int t, input work_state_e st, input logic [6:0] fl);
        exp_t e;
        e.t = t; e.st = st; e.cmd = C_NOP; e.ba_care = 1'b0; e.ba = 2'd0;
        e.addr = 13'd0; e.amask = 13'd0; e.fl = fl;
        return e;
    endfunction

    function automatic exp_t mkc(input int t, input work_state_e st, input logic [3:0] cmd,
                                 input logic ba_care, input logic [1:0] ba,
                                 input logic [12:0] addr, input logic [12:0] amask,
                                 input logic [6:0] fl);
        exp_t e;
        e = mk(t, st, fl);
        e.cmd = cmd; e.ba_care = ba_care; e.ba = ba; e.addr = addr; e.amask = amask;
        return e;
    endfunction

    task automatic push_upto(input exp_t e, input int t0, input int upto);
        if (e.t - t0 <= upto) sb.push_back(e);
    endtask

    // Granted read starting in S_IDLE cycle t0; records past offset upto are dropped.
    task automatic push_read(input int t0, input logic [23:0] a, input int upto);
        logic [1:0]  ba;
        logic [12:0] row, col;
        ba = a[23:22]; row = a[21:9]; col = {4'b0, a[8:0]};
        push_upto(mk(t0, S_IDLE, F_RWN | F_RACK), t0, upto);
        push_upto(mkc(t0 + 1, S_ACTIVE, C_ACT, 1'b1, ba, row, 13'h1fff, F_RWN), t0, upto);
        push_upto(mk(t0 + 2, S_TRCD, F_RWN), t0, upto);
        push_upto(mkc(t0 + 3, S_READ, C_RD, 1'b1, ba, col, 13'h1fff, F_RWN), t0, upto);
        for (int i = 4; i < 6; i++) push_upto(mk(t0 + i, S_CL, F_RWN), t0, upto);
        for (int i = 6; i < 10; i++)
            push_upto(mk(t0 + i, S_RD_DATA, F_RWN | F_DIV | ((i == 9) ? F_ENDR : 7'b0)), t0, upto);
        push_upto(mkc(t0 + 10, S_PRECH, C_PRE, 1'b0, 2'd0, 13'h0400, 13'h0400, F_RWN), t0, upto);
        push_upto(mk(t0 + 11, S_TRP, F_RWN), t0, upto);
    endtask

    // Granted write starting in S_IDLE cycle t0; back in S_IDLE at t0+11.
    task automatic push_write(input int t0, input logic [23:0] a);
        logic [1:0]  ba;
        logic [12:0] row, col;
        ba = a[23:22]; row = a[21:9]; col = {4'b0, a[8:0]};
        sb.push_back(mk(t0, S_IDLE, F_RWN | F_WACK));
        sb.push_back(mkc(t0 + 1, S_ACTIVE, C_ACT, 1'b1, ba, row, 13'h1fff, F_RWN));
        sb.push_back(mk(t0 + 2, S_TRCD, F_RWN));
        sb.push_back(mkc(t0 + 3, S_WR_DATA, C_WR, 1'b1, ba, col, 13'h1fff, F_WDV));
        for (int i = 4; i < 7; i++)
            sb.push_back(mk(t0 + i, S_WR_DATA, F_WDV | ((i == 6) ? F_ENDW : 7'b0)));
        for (int i = 7; i < 9; i++) sb.push_back(mk(t0 + i, S_TWR, F_RWN));
        sb.push_back(mkc(t0 + 9, S_PRECH, C_PRE, 1'b0, 2'd0, 13'h0400, 13'h0400, F_RWN));
        sb.push_back(mk(t0 + 10, S_TRP, F_RWN));
    endtask

    task automatic compare_now();
        exp_t e;
        if (sb.size() == 0) return;
        if (sb[0].t != cyc) return;
        e = sb.pop_front();
        chk("work_state", 32'(work_state), 32'(e.st));
        chk("sdram_cmd", 32'(sdram_cmd), 32'(e.cmd));
        chk("flags", 32'(obs_fl), 32'(e.fl));
        if (e.ba_care) chk("sdram_ba", 32'(sdram_ba), 32'(e.ba));
        if (e.amask != 13'd0) chk("sdram_addr", 32'(sdram_addr & e.amask), 32'(e.addr & e.amask));
        if (prev_valid && prev_t == cyc - 1)
            chk("cur_work_state", 32'(cur_work_state), 32'(prev_st));
        prev_valid = 1'b1;
        prev_t     = cyc;
        prev_st    = e.st;
    endtask

    // Check the current cycle at the falling edge, then move 1 ns past the next rising edge.
    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_now();
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        @(negedge clk);
        chk({tag, "_state"}, 32'(work_state), 32'(S_IDLE));
        chk({tag, "_cur_state"}, 32'(cur_work_state), 32'(S_IDLE));
        chk({tag, "_cmd"}, 32'(sdram_cmd), 32'(C_NOP));
        chk({tag, "_ba"}, 32'(sdram_ba), 32'd0);
        chk({tag, "_addr"}, 32'(sdram_addr), 32'd0);
        chk({tag, "_flags"}, 32'(obs_fl), 32'(F_RWN));
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, e0;
        rst = 1'b1; init_done = 1'b0; sdram_rd_req = 1'b0; sdram_wr_req = 1'b0;
        sys_rdaddr = 24'd0; sys_wraddr = 24'd0;
        @(posedge clk); cyc++; #1;
        @(posedge clk); cyc++; #1;
        rst = 1'b0;
        chk_reset("reset");

        // Read held while init_done is low: no grant until one cycle after it rises.
        sdram_rd_req = 1'b1; sys_rdaddr = 24'h40_1234;
        for (int i = 0; i < 5; i++) sb.push_back(mk(cyc + i, S_IDLE, F_RWN));
        adv(5);
        init_done = 1'b1;
        sb.push_back(mk(cyc, S_IDLE, F_RWN));
        t0 = cyc + 1;
        e0 = t0;
        push_read(t0, 24'h40_1234, 99);
        adv(2);
        sdram_rd_req = 1'b0;
        adv(11);
        sb.push_back(mk(t0 + 12, S_IDLE, F_RWN));
        adv(1);

        // Single write at column 5.
        t0 = cyc;
        sdram_wr_req = 1'b1; sys_wraddr = 24'h00_0005;
        push_write(t0, 24'h00_0005);
        adv(1);
        sdram_wr_req = 1'b0;
        adv(10);
        sb.push_back(mk(t0 + 11, S_IDLE, F_RWN));
        adv(1);

        // Simultaneous requests: write wins, read is granted at the next idle.
        t0 = cyc;
        sdram_wr_req = 1'b1; sys_wraddr = 24'h7F_FFFF;
        sdram_rd_req = 1'b1; sys_rdaddr = 24'hC0_2A0F;
        push_write(t0, 24'h7F_FFFF);
        adv(1);
        sdram_wr_req = 1'b0;
        adv(10);
        push_read(t0 + 11, 24'hC0_2A0F, 99);
        adv(1);
        sdram_rd_req = 1'b0;
        adv(11);
        sb.push_back(mk(t0 + 23, S_IDLE, F_RWN));
        adv(1);

        // Refresh interval expires mid-read (counter reads 775 at the grant).
        adv(e0 + 775 - cyc);
        t0 = cyc;
        sdram_rd_req = 1'b1; sys_rdaddr = 24'h40_1234;
        push_read(t0, 24'h40_1234, 99);
        adv(1);
        sys_rdaddr = 24'h01_0203;
        adv(11);
        sb.push_back(mk(t0 + 12, S_IDLE, F_RWN));
        sb.push_back(mkc(t0 + 13, S_AR, C_AR, 1'b0, 2'd0, 13'd0, 13'd0, F_RWN));
        for (int i = 14; i < 20; i++) sb.push_back(mk(t0 + i, S_TRFC, F_RWN));
        push_read(t0 + 20, 24'h01_0203, 99);
        adv(9);
        sdram_rd_req = 1'b0;
        adv(11);
        sb.push_back(mk(t0 + 32, S_IDLE, F_RWN));
        adv(1);

        // Reset during the CAS latency of a read.
        t0 = cyc;
        sdram_rd_req = 1'b1; sys_rdaddr = 24'h12_3456;
        push_read(t0, 24'h12_3456, 4);
        adv(1);
        sdram_rd_req = 1'b0;
        adv(3);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        chk_reset("midburst_rst");
        for (int i = 0; i < 3; i++) sb.push_back(mk(cyc + i, S_IDLE, F_RWN));
        adv(3);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_work_fsm.md
SDRAM_WORK_FSM -- requirements
Module: sdram_work_fsm

Interface
REQ-001 Parameters SHALL be:
- BL, 4, burst length in words
- CL, 3, CAS latency in cycles
- T_RCD, 2, ACTIVE-to-READ/WRITE cycles
- T_RP, 2, PRECHARGE-to-next-command cycles
- T_WR, 2, write recovery cycles
- T_RFC, 7, AUTO REFRESH duration in cycles
- REF_INTERVAL, 780, cycles between refresh requests
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done  in  1  SDRAM power-up sequence complete
- sdram_rd_req  in  1  read burst request, held until acked
- sdram_wr_req  in  1  write burst request, held until acked
- sys_rdaddr  in  24  read address {ba[23:22], row[21:9], col[8:0]}
- sys_wraddr  in  24  write address, same map
- sdram_rd_ack  out  1  read grant pulse
- sdram_wr_ack  out  1  write grant pulse
- sdram_wr_data_valid  out  1  write data pop strobe
- sdram_data_i_valid  out  1  read data capture strobe
- end_tread  out  1  last read data cycle
- end_twrite  out  1  last write data cycle
- sdram_r_wn  out  1  0 while driving DQ
- work_state  out  5  current state
- cur_work_state  out  5  work_state delayed one cycle
- sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n}
- sdram_ba  out  2  bank address
- sdram_addr  out  13  row/column address

Function
REQ-004 States SHALL be S_IDLE, S_ACTIVE, S_TRCD, S_READ, S_CL, S_RD_DATA, S_WR_DATA, S_TWR, S_PRECH, S_TRP, S_AR, S_TRFC.
REQ-005 Commands SHALL be encoded as NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO REFRESH 0001; every other cycle SHALL carry NOP.
REQ-006 The block SHALL hold S_IDLE, issue no ack, and hold the refresh counter at 0 while init_done=0.
REQ-007 The refresh counter SHALL count to REF_INTERVAL-1, set ref_pending, and wrap to 0.
REQ-008 The counter SHALL keep running during bursts; ref_pending SHALL clear on entry to S_AR.
REQ-009 Arbitration in S_IDLE SHALL give priority ref_pending > sdram_wr_req > sdram_rd_req.
REQ-010 The ack SHALL be combinational and asserted only in the S_IDLE cycle that grants it; it is never asserted while ref_pending=1.
REQ-011 The granting edge SHALL latch the selected address and select the next state: S_ACTIVE for read/write, S_AR for refresh.
REQ-012 S_ACTIVE SHALL issue ACTIVE with the latched ba and row for 1 cycle, then S_TRCD SHALL last T_RCD-1 cycles.
REQ-013 The read path SHALL be: S_READ (READ, addr={0,col}, 1 cycle), S_CL (CL-1 cycles), S_RD_DATA (BL cycles, sdram_data_i_valid=1).
REQ-014 The write path SHALL be: S_WR_DATA for BL cycles with sdram_wr_data_valid=1 and sdram_r_wn=0; WRITE (addr={0,col}) is issued on the first cycle.
REQ-015 end_tread and end_twrite SHALL pulse high on the final S_RD_DATA and S_WR_DATA cycle respectively.
REQ-016 S_TWR SHALL last T_WR cycles after write data, then go to S_PRECH.
REQ-017 S_PRECH SHALL issue PRECHARGE with addr[10]=1 for 1 cycle, then S_TRP SHALL last T_RP-1 cycles, then return to S_IDLE.
REQ-018 S_AR SHALL issue AUTO REFRESH for 1 cycle, then S_TRFC SHALL last T_RFC-1 cycles, then return to S_IDLE.
REQ-019 A single 4-bit wait counter SHALL time all multi-cycle states and reload to 0 on every state change.
REQ-020 A request arriving mid-burst SHALL be held off with no ack and served at the next S_IDLE per REQ-009.

Reset
REQ-021 On rst, the following SHALL be set synchronously: state S_IDLE; cur_work_state S_IDLE; sdram_cmd 0111; ba/addr 0; sdram_r_wn 1; all acks, strobes and end_* 0; all counters 0; ref_pending 0.
REQ-022 A reset asserted mid-burst SHALL abort on the next edge with no further commands.

Structure
REQ-023 The state codes, command encodings and address-field bounds SHALL live in the shared sdram_param package.
REQ-024 The refresh timer SHALL be one sub-module, sdram_ref_timer.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Read, sys_rdaddr=24'h40_1234, T0 ack: ACTIVE at T1 (ba=1, row=0x009); READ at T3 (col=0x034); data_i_valid at T6..T9; end_tread at T9; PRECHARGE at T10; S_IDLE at T12.
- Write, sys_wraddr=24'h00_0005: WRITE at T3 (col=5); wr_data_valid and r_wn=0 at T3..T6; end_twrite at T6; PRECHARGE at T9.
- Simultaneous rd_req and wr_req: wr_ack first; rd_ack at the first S_IDLE after the write.
- Counter at 779 during a read: no ack; AUTO REFRESH at the next S_IDLE; S_TRFC lasts 6 cycles.
- rst at T4 of a read: next cycle NOP, S_IDLE, all strobes 0.
- init_done=0 with req held: no ack; ack 1 cycle after init_done rises.
